// File: rtl/systolic_seq_ctrl.sv
// Unified MAC-array sequencer: clears the array, loads one weight per MAC,
// streams the input vector, waits for the skewed valids and the accumulators
// to settle, captures every accumulator, then streams the results out over
// a valid/ready handshake.
module systolic_seq_ctrl #(
  parameter int unsigned N_MACS  = 4,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned K_MAX   = 64,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ACC_LAT = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [$clog2(K_MAX+1)-1:0]                     k_len,
  input  logic [ADDR_W-1:0]                              w_base,
  input  logic [ADDR_W-1:0]                              in_base,
  output logic                                           busy,
  output logic                                           done,
  output logic [N_MACS-1:0]                              clear,
  output logic                                           w_load,
  output logic [ADDR_W-1:0]                              w_addr,
  output logic [N_MACS-1:0]                              weight_sel,
  output logic                                           in_load,
  output logic [ADDR_W-1:0]                              in_addr,
  output logic [N_MACS-1:0]                              valid_ctrl,
  input  logic [N_MACS*ACC_W-1:0]                        acc_in,
  output logic [ACC_W-1:0]                               res_data,
  output logic [((N_MACS > 1) ? $clog2(N_MACS) : 1)-1:0] res_idx,
  output logic                                           res_valid,
  input  logic                                           res_ready
);

  localparam int unsigned KW        = $clog2(K_MAX + 1);
  localparam int unsigned IDX_W     = (N_MACS > 1) ? $clog2(N_MACS) : 1;
  localparam int unsigned DRAIN_LEN = MEM_LAT + N_MACS - 1 + ACC_LAT;
  localparam int unsigned HIST_RAW  = MEM_LAT + N_MACS - 1;
  localparam int unsigned HIST_W    = (HIST_RAW > 0) ? HIST_RAW : 1;
  localparam int unsigned CNT_MAX_A = (N_MACS > K_MAX) ? N_MACS : K_MAX;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > DRAIN_LEN) ? CNT_MAX_A : DRAIN_LEN;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [N_MACS-1:0] SEL_ONE = N_MACS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [KW-1:0]      k_eff_q;
  logic [ADDR_W-1:0]  w_base_q, in_base_q;
  logic [ACC_W-1:0]   cap_q [N_MACS];
  logic [ACC_W-1:0]   acc_word [N_MACS];
  logic [HIST_W-1:0]  hist_q;
  logic               capture;

  logic               busy_n, done_n, w_load_n, in_load_n, res_valid_n;
  logic [N_MACS-1:0]  clear_n, weight_sel_n;
  logic [ADDR_W-1:0]  w_addr_n, in_addr_n;
  logic [ACC_W-1:0]   res_data_n;
  logic [IDX_W-1:0]   res_idx_n;

  // Split the flattened accumulator bus into per-MAC words.
  for (genvar g = 0; g < N_MACS; g++) begin : g_acc
    assign acc_word[g] = acc_in[g*ACC_W +: ACC_W];
  end

  // Per-MAC valid taps: MAC m sees in_load delayed by MEM_LAT+m cycles.
  for (genvar m = 0; m < N_MACS; m++) begin : g_valid
    localparam int unsigned DLY = MEM_LAT + m;
    if (DLY == 0) begin : g_direct
      assign valid_ctrl[m] = in_load;
    end else begin : g_tap
      assign valid_ctrl[m] = hist_q[DLY-1];
    end
  end

  // Next-state, phase counter and next registered output values.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    done_n       = 1'b0;
    capture      = 1'b0;
    busy_n       = 1'b0;
    clear_n      = '0;
    w_load_n     = 1'b0;
    w_addr_n     = '0;
    weight_sel_n = '0;
    in_load_n    = 1'b0;
    in_addr_n    = '0;
    res_valid_n  = 1'b0;
    res_data_n   = '0;
    res_idx_n    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
        end
      end
      S_CLEAR: begin
        state_n = S_LOAD_W;
        cnt_n   = '0;
      end
      S_LOAD_W: begin
        if (cnt_q == CNT_W'(N_MACS - 1)) begin
          cnt_n   = '0;
          state_n = (k_eff_q == '0) ? S_DRAIN : S_STREAM;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_STREAM: begin
        if ((cnt_q + CNT_W'(1)) == CNT_W'(k_eff_q)) begin
          cnt_n   = '0;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
          cnt_n   = '0;
          state_n = S_OUT;
          capture = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (res_valid && res_ready) begin
          if (cnt_q == CNT_W'(N_MACS - 1)) begin
            cnt_n   = '0;
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs describe the phase being entered, so they line up with state_q.
    busy_n    = (state_n != S_IDLE);
    clear_n   = (state_n == S_CLEAR) ? '1 : '0;
    w_load_n  = (state_n == S_LOAD_W);
    in_load_n = (state_n == S_STREAM);
    if (w_load_n) begin
      w_addr_n     = w_base_q + ADDR_W'(cnt_n);
      weight_sel_n = SEL_ONE << cnt_n;
    end
    if (in_load_n) begin
      in_addr_n = in_base_q + ADDR_W'(cnt_n);
    end
    res_valid_n = (state_n == S_OUT);
    if (res_valid_n) begin
      res_idx_n  = IDX_W'(cnt_n);
      // On the capture edge the bank is not yet loaded, so bypass word 0.
      res_data_n = capture ? acc_word[0] : cap_q[IDX_W'(cnt_n)];
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clear      <= '0;
      w_load     <= 1'b0;
      w_addr     <= '0;
      weight_sel <= '0;
      in_load    <= 1'b0;
      in_addr    <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_idx    <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      clear      <= clear_n;
      w_load     <= w_load_n;
      w_addr     <= w_addr_n;
      weight_sel <= weight_sel_n;
      in_load    <= in_load_n;
      in_addr    <= in_addr_n;
      res_valid  <= res_valid_n;
      res_data   <= res_data_n;
      res_idx    <= res_idx_n;
    end
  end

  // Job configuration latched on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_eff_q   <= '0;
      w_base_q  <= '0;
      in_base_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      k_eff_q   <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
      w_base_q  <= w_base;
      in_base_q <= in_base;
    end
  end

  // Accumulator capture bank, loaded on the last drain cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_MACS; i++) cap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_MACS; i++) cap_q[i] <= acc_word[i];
    end
  end

  // in_load history; free-running so valids keep draining after STREAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q[0] <= in_load;
      for (int i = 1; i < HIST_W; i++) hist_q[i] <= hist_q[i-1];
    end
  end

endmodule
